// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, optional iterative mul/div FSM (EX_MULDIV_EN)
// and the EX/MEM pipeline register.
module ex_stage #(
    parameter logic [4:0]  LINK_REG  = 5'd31,
    parameter logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_EX_Rs,
    input  logic [31:0] ID_EX_Rt,
    input  logic [31:0] ID_EX_ImmExt,
    input  logic [4:0]  ID_EX_RtAddr,
    input  logic [4:0]  ID_EX_RdAddr,
    input  logic [3:0]  ID_EX_ALUOp,
    input  logic        ID_EX_ALUSrc1,
    input  logic        ID_EX_ALUSrc2,
    input  logic [1:0]  ID_EX_RegDst,
    input  logic        ID_EX_MemRd,
    input  logic        ID_EX_MemWr,
    input  logic        ID_EX_RegWr,
    input  logic [1:0]  ID_EX_MemtoReg,
    input  logic [31:0] ID_EX_PC4,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] MEM_WB_WrData,
    output logic        ex_busy,
    output logic [31:0] EX_MEM_ALUOut,
    output logic [31:0] EX_MEM_WrData,
    output logic [31:0] EX_MEM_PC4,
    output logic [4:0]  EX_MEM_WrAddr,
    output logic        EX_MEM_MemRd,
    output logic        EX_MEM_MemWr,
    output logic        EX_MEM_RegWr,
    output logic [1:0]  EX_MEM_MemtoReg
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] f_a, f_b, op_a, op_b, alu_res;
    logic [4:0]      wr_addr;

    always_comb begin
        case (ForwardA)
            2'b01:   f_a = EX_MEM_ALUOut;
            2'b10:   f_a = MEM_WB_WrData;
            default: f_a = ID_EX_Rs;
        endcase
        case (ForwardB)
            2'b01:   f_b = EX_MEM_ALUOut;
            2'b10:   f_b = MEM_WB_WrData;
            default: f_b = ID_EX_Rt;
        endcase
    end

    assign op_a = ID_EX_ALUSrc1 ? {27'b0, ID_EX_ImmExt[10:6]} : f_a;
    assign op_b = ID_EX_ALUSrc2 ? ID_EX_ImmExt : f_b;

    // Single-cycle ALU; mul/div opcodes fall into the zero default
    always_comb begin
        alu_res = '0;
        case (ID_EX_ALUOp)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = ~(op_a | op_b);
            4'd6:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            4'd7:    alu_res = XLEN'(op_a < op_b);
            4'd8:    alu_res = op_b << op_a[4:0];
            4'd9:    alu_res = op_b >> op_a[4:0];
            4'd10:   alu_res = XLEN'($signed(op_b) >>> op_a[4:0]);
            4'd11:   alu_res = {op_b[15:0], 16'h0000};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (ID_EX_RegDst)
            2'b00:   wr_addr = ID_EX_RtAddr;
            2'b01:   wr_addr = ID_EX_RdAddr;
            2'b10:   wr_addr = LINK_REG;
            default: wr_addr = 5'd0;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [3:0]      md_op;
    logic [4:0]      md_cnt;
    logic [XLEN-1:0] md_a, md_b, md_acc, md_res;
    logic [XLEN:0]   rem_sh, rem_sub;
    logic            is_md;

    assign is_md   = (ID_EX_ALUOp == 4'd12) || (ID_EX_ALUOp == 4'd13) || (ID_EX_ALUOp == 4'd14);
    assign ex_busy = ((state == IDLE) && is_md) || (state == BUSY);

    // Restoring divide: md_a shifts dividend out / quotient in, md_acc holds the remainder
    assign rem_sh  = {md_acc, md_a[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, md_b};

    always_comb begin
        case (md_op)
            4'd12:   md_res = md_acc;
            4'd13:   md_res = (md_b == '0) ? DIVZERO_Q : md_a;
            4'd14:   md_res = md_acc;
            default: md_res = '0;
        endcase
    end
`else
    assign ex_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            EX_MEM_ALUOut   <= '0;
            EX_MEM_WrData   <= '0;
            EX_MEM_PC4      <= '0;
            EX_MEM_WrAddr   <= '0;
            EX_MEM_MemRd    <= 1'b0;
            EX_MEM_MemWr    <= 1'b0;
            EX_MEM_RegWr    <= 1'b0;
            EX_MEM_MemtoReg <= '0;
`ifdef EX_MULDIV_EN
            state  <= IDLE;
            md_op  <= '0;
            md_cnt <= '0;
            md_a   <= '0;
            md_b   <= '0;
            md_acc <= '0;
`endif
        end else begin
            EX_MEM_ALUOut   <= alu_res;
            EX_MEM_WrData   <= f_b;
            EX_MEM_PC4      <= ID_EX_PC4;
            EX_MEM_WrAddr   <= wr_addr;
            EX_MEM_MemRd    <= ID_EX_MemRd;
            EX_MEM_MemWr    <= ID_EX_MemWr;
            EX_MEM_RegWr    <= ID_EX_RegWr;
            EX_MEM_MemtoReg <= ID_EX_MemtoReg;
`ifdef EX_MULDIV_EN
            case (state)
                IDLE: begin
                    if (is_md) begin
                        md_op        <= ID_EX_ALUOp;
                        md_cnt       <= '0;
                        md_a         <= op_a;
                        md_b         <= op_b;
                        md_acc       <= '0;
                        EX_MEM_MemRd <= 1'b0;
                        EX_MEM_MemWr <= 1'b0;
                        EX_MEM_RegWr <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (md_op == 4'd12) begin
                        if (md_b[0]) md_acc <= md_acc + md_a;
                        md_a <= md_a << 1;
                        md_b <= md_b >> 1;
                    end else if (!rem_sub[XLEN]) begin
                        md_acc <= rem_sub[XLEN-1:0];
                        md_a   <= {md_a[XLEN-2:0], 1'b1};
                    end else begin
                        md_acc <= rem_sh[XLEN-1:0];
                        md_a   <= {md_a[XLEN-2:0], 1'b0};
                    end
                    md_cnt       <= 5'(md_cnt + 5'd1);
                    EX_MEM_MemRd <= 1'b0;
                    EX_MEM_MemWr <= 1'b0;
                    EX_MEM_RegWr <= 1'b0;
                    if (md_cnt == 5'd31) state <= DONE;
                end
                DONE: begin
                    EX_MEM_ALUOut <= md_res;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Contents: operand forwarding muxes, the ALU, an iterative multiply/divide FSM, and the EX/MEM pipeline register.
- Drives ex_busy to the hazard unit. The hazard unit holds ID/EX (stall code 10) and IF/ID while a multi-cycle op runs.

Parameters:
- LINK_REG, 31: destination register number when RegDst=10 (JAL).
- DIVZERO_Q, 32'hFFFFFFFF: quotient returned by DIVU on divide-by-zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ID_EX_Rs, ID_EX_Rt  in  32 each  register operands
- ID_EX_ImmExt  in  32  extended immediate; [10:6] is shamt
- ID_EX_RtAddr, ID_EX_RdAddr  in  5 each  destination candidates
- ID_EX_ALUOp  in  4  operation code
- ID_EX_ALUSrc1  in  1  1: A = shamt
- ID_EX_ALUSrc2  in  1  1: B = ImmExt
- ID_EX_RegDst  in  2  00 rt, 01 rd, 10 LINK_REG
- ID_EX_MemRd, ID_EX_MemWr, ID_EX_RegWr  in  1 each  control
- ID_EX_MemtoReg  in  2  control
- ID_EX_PC4  in  32  PC+4
- ForwardA, ForwardB  in  2 each  00 ID/EX value, 01 EX_MEM_ALUOut, 10 MEM_WB_WrData
- MEM_WB_WrData  in  32  writeback-stage value
- ex_busy  out  1  multi-cycle op in progress; upstream must stall
- EX_MEM_ALUOut, EX_MEM_WrData, EX_MEM_PC4  out  32 each  registered outputs
- EX_MEM_WrAddr  out  5  registered destination
- EX_MEM_MemRd, EX_MEM_MemWr, EX_MEM_RegWr  out  1 each  registered control
- EX_MEM_MemtoReg  out  2  registered control

Behaviour:
- Reset (rst=1 at posedge): every EX_MEM_* output is zero, FSM goes to IDLE, ex_busy=0. This applies mid-operation too; the partial result is discarded.
- Forwarding: fA/fB come from the ForwardA/ForwardB select. Code 11 behaves as 00.
- Operand A = ALUSrc1 ? {27'b0, ImmExt[10:6]} : fA.
- Operand B = ALUSrc2 ? ImmExt : fB.
- EX_MEM_WrData always takes fB.
- ALUOp encoding (all arithmetic mod 2^32, no overflow traps):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL B by A[4:0], 9 SRL, 10 SRA
  - 11 LUI: B<<16
  - 12 MUL: low 32 bits of A*B
  - 13 DIVU: A/B, 14 REMU: A%B
  - 15: result 0
- Divide-by-zero: DIVU returns DIVZERO_Q; REMU returns A.
- WrAddr: rt, rd or LINK_REG per RegDst. RegDst=11 gives 0.
- Single-cycle ops (0-11, 15): result registered into EX_MEM at the next edge (1-cycle latency). All control passes through.
- FSM states IDLE, BUSY, DONE:
  - IDLE with ALUOp in {12,13,14}:
    - ex_busy=1 combinationally; latch A, B and op; cnt=0; go to BUSY.
    - EX_MEM loads a bubble: RegWr, MemRd, MemWr = 0.
  - BUSY:
    - One shift-add (MUL) or restoring-subtract (DIVU/REMU) iteration per cycle; cnt increments.
    - ex_busy=1; EX_MEM loads a bubble.
    - At cnt==31, go to DONE.
  - DONE:
    - ex_busy=0; EX_MEM loads the latched result plus the current ID/EX control; go to IDLE.
  - Total: the instruction occupies EX for 34 cycles, with 33 stall cycles.
- Held operands: ID/EX is held during busy, so control and addresses are stable. Operands are used only from the IDLE latch, so forwarding changes during BUSY are ignored.
- Back-to-back: a muldiv op entering in the cycle after DONE starts a fresh sequence from IDLE.

Optional Feature:
- Macro EX_MULDIV_EN.
- Defined: FSM and ops 12-14 as above.
- Undefined:
  - No FSM; ex_busy is tied to 0.
  - Ops 12-14 produce result 0 in a single cycle, like op 15.

Test Plan:
- Reset mid-sequence: assert rst during BUSY (cnt=10) -> next cycle ex_busy=0, all EX_MEM_* = 0; the next ADD 3+4 gives ALUOut=7.
- Forwarding: Rs=1, ForwardA=01 with EX_MEM_ALUOut=0x10; Rt=2, ForwardB=10 with MEM_WB_WrData=0x5, SUB -> ALUOut=0xB, WrData=0x5.
- Shift/LUI: ALUSrc1=1, ImmExt[10:6]=4, B=0x80000000, SRA -> 0xF8000000; LUI with ImmExt=0x1234 -> 0x12340000.
- MUL 0xFFFFFFFF*3 -> ex_busy high exactly 33 cycles, ALUOut=0xFFFFFFFD, RegWr=1 only on the result cycle, bubbles before it.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- JAL: RegDst=10, MemtoReg=10, PC4=0x00400008 -> WrAddr=31, EX_MEM_PC4=0x00400008.
